// File: rtl/multi_counter_pkg.sv
// Shared constants and helpers for the multi-channel counter bank.
package multi_counter_pkg;

    // Values accepted by the SATURATE parameter
    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    // Largest count representable in 'width' bits
    function automatic int unsigned cnt_max(int unsigned width);
        return (1 << width) - 1;
    endfunction

    // Low bit index of channel 'ch' inside a packed channel vector
    function automatic int unsigned slice_lo(int unsigned ch, int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/multi_counter_if.sv
// Control and status bundle of the counter bank; master drives controls, slave is the bank.
interface multi_counter_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2
) ();
    logic [CHANNELS-1:0]       en;
    logic [CHANNELS-1:0]       up;
    logic [CHANNELS-1:0]       load;
    logic [CHANNELS*WIDTH-1:0] load_val;
    logic [CHANNELS-1:0]       clr_flags;
    logic [CHANNELS*WIDTH-1:0] count;
    logic [CHANNELS-1:0]       at_limit;
    logic [CHANNELS-1:0]       ovf;
    logic [CHANNELS-1:0]       udf;
    logic                      any_limit;
    logic                      first_cycle;

    modport master (
        output en, up, load, load_val, clr_flags,
        input  count, at_limit, ovf, udf, any_limit, first_cycle
    );

    modport slave (
        input  en, up, load, load_val, clr_flags,
        output count, at_limit, ovf, udf, any_limit, first_cycle
    );
endinterface

// File: rtl/multi_counter_lane.sv
// One counter channel: count register, sticky ovf/udf flags and limit compare.
module multi_counter_lane
    import multi_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned LIMIT    = 10,
    parameter int unsigned SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             clr_flag_i,
    output logic [WIDTH-1:0] count_o,
    output logic             at_limit_o,
    output logic             ovf_o,
    output logic             udf_o
);

    localparam logic [WIDTH-1:0] CntMax = WIDTH'(cnt_max(WIDTH));
    localparam logic [WIDTH-1:0] Limit  = WIDTH'(LIMIT);
    localparam bit               Sat    = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    // Next state: load beats count step; a flag set beats a same-cycle clear
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q & ~clr_flag_i;
        udf_d   = udf_q & ~clr_flag_i;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            if (up_i) begin
                if (count_q == CntMax) begin
                    ovf_d   = 1'b1;
                    count_d = Sat ? CntMax : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    udf_d   = 1'b1;
                    count_d = Sat ? '0 : CntMax;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Outputs straight from the registers
    always_comb begin
        count_o    = count_q;
        ovf_o      = ovf_q;
        udf_o      = udf_q;
        at_limit_o = (count_q >= Limit);
    end

endmodule

// File: rtl/multi_counter.sv
// Multi-channel up/down counter bank with load, wrap/saturate, limit compare and sticky flags.
// Define MULTI_COUNTER_ASSERT_EN to add property checks and a shadow previous-count register.
module multi_counter
    import multi_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned LIMIT    = 10,
    parameter int unsigned SATURATE = MODE_WRAP
) (
    input  logic            clk,
    input  logic            rst,
    multi_counter_if.slave  bus
);

    logic first_cycle_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        multi_counter_lane #(
            .WIDTH    (WIDTH),
            .LIMIT    (LIMIT),
            .SATURATE (SATURATE)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .en_i       (bus.en[i]),
            .up_i       (bus.up[i]),
            .load_i     (bus.load[i]),
            .load_val_i (bus.load_val[slice_lo(i, WIDTH) +: WIDTH]),
            .clr_flag_i (bus.clr_flags[i]),
            .count_o    (bus.count[slice_lo(i, WIDTH) +: WIDTH]),
            .at_limit_o (bus.at_limit[i]),
            .ovf_o      (bus.ovf[i]),
            .udf_o      (bus.udf[i])
        );
    end

    // first_cycle is high for the single cycle following a reset edge
    always_ff @(posedge clk) begin
        if (rst) begin
            first_cycle_q <= 1'b1;
        end else begin
            first_cycle_q <= 1'b0;
        end
    end

    // Bank-level status outputs
    always_comb begin
        bus.first_cycle = first_cycle_q;
        bus.any_limit   = |bus.at_limit;
    end

`ifdef MULTI_COUNTER_ASSERT_EN
    localparam logic [WIDTH-1:0] CntMax = WIDTH'(cnt_max(WIDTH));

    logic [CHANNELS*WIDTH-1:0] prev_q;

    // Shadow copy of the previous cycle's counts for the transition check
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= bus.count;
        end
    end

    // (a) is deliberately violable: it gives a model checker a reachable target
    always @* begin
        if (!first_cycle_q) begin
            for (int i = 0; i < CHANNELS; i++) begin
                assert (bus.count[i*WIDTH +: WIDTH] < WIDTH'(LIMIT))
                    else $error("count %0d reached LIMIT", i);
                if (SATURATE == MODE_SAT) begin
                    assert (!((prev_q[i*WIDTH +: WIDTH] == CntMax) &&
                              (bus.count[i*WIDTH +: WIDTH] == '0)) &&
                            !((prev_q[i*WIDTH +: WIDTH] == '0) &&
                              (bus.count[i*WIDTH +: WIDTH] == CntMax)))
                        else $error("saturating count %0d jumped across range", i);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_multi_counter.sv
// Directed plus random bench for multi_counter; one wrapping and one saturating instance
// share the same stimulus and are compared against an integer reference model.
module tb_multi_counter;

    localparam int W    = 4;
    localparam int CH   = 2;
    localparam int LIM  = 10;
    localparam int MAXV = 15;

    logic          clk;
    logic          rst;
    logic [CH-1:0] en, up, load, clr;
    logic [CH*W-1:0] lval;

    int checks = 0;
    int errors = 0;

    // Reference model: [instance 0 = wrap, 1 = saturate][channel]
    int m_cnt [2][CH];
    bit m_ovf [2][CH];
    bit m_udf [2][CH];
    bit m_first;

    multi_counter_if #(.WIDTH(W), .CHANNELS(CH)) bus_w ();
    multi_counter_if #(.WIDTH(W), .CHANNELS(CH)) bus_s ();

    assign bus_w.en = en;
    assign bus_w.up = up;
    assign bus_w.load = load;
    assign bus_w.load_val = lval;
    assign bus_w.clr_flags = clr;
    assign bus_s.en = en;
    assign bus_s.up = up;
    assign bus_s.load = load;
    assign bus_s.load_val = lval;
    assign bus_s.clr_flags = clr;

    multi_counter #(.WIDTH(W), .CHANNELS(CH), .LIMIT(LIM), .SATURATE(0)) u_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    multi_counter #(.WIDTH(W), .CHANNELS(CH), .LIMIT(LIM), .SATURATE(1)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model advance using the inputs present at the clock edge
    task automatic model_step();
        if (rst) begin
            m_first = 1'b1;
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < CH; i++) begin
                    m_cnt[k][i] = 0;
                    m_ovf[k][i] = 1'b0;
                    m_udf[k][i] = 1'b0;
                end
        end else begin
            m_first = 1'b0;
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < CH; i++) begin
                    bit so = 1'b0;
                    bit su = 1'b0;
                    if (load[i]) begin
                        m_cnt[k][i] = int'(lval[i*W +: W]);
                    end else if (en[i]) begin
                        int nv = m_cnt[k][i] + (up[i] ? 1 : -1);
                        if (nv > MAXV) begin
                            so = 1'b1;
                            nv = (k == 1) ? MAXV : 0;
                        end else if (nv < 0) begin
                            su = 1'b1;
                            nv = (k == 1) ? 0 : MAXV;
                        end
                        m_cnt[k][i] = nv;
                    end
                    m_ovf[k][i] = so | (m_ovf[k][i] & ~clr[i]);
                    m_udf[k][i] = su | (m_udf[k][i] & ~clr[i]);
                end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            bit any = 1'b0;
            for (int i = 0; i < CH; i++) begin
                int cnt = k ? int'(bus_s.count[i*W +: W]) : int'(bus_w.count[i*W +: W]);
                int lim = k ? int'(bus_s.at_limit[i]) : int'(bus_w.at_limit[i]);
                int ov  = k ? int'(bus_s.ovf[i]) : int'(bus_w.ovf[i]);
                int ud  = k ? int'(bus_s.udf[i]) : int'(bus_w.udf[i]);
                bit el  = (m_cnt[k][i] >= LIM);
                any = any | el;
                chk($sformatf("m%0d_count%0d", k, i), cnt, m_cnt[k][i]);
                chk($sformatf("m%0d_at_limit%0d", k, i), lim, int'(el));
                chk($sformatf("m%0d_ovf%0d", k, i), ov, int'(m_ovf[k][i]));
                chk($sformatf("m%0d_udf%0d", k, i), ud, int'(m_udf[k][i]));
            end
            chk($sformatf("m%0d_any_limit", k),
                k ? int'(bus_s.any_limit) : int'(bus_w.any_limit), int'(any));
            chk($sformatf("m%0d_first_cycle", k),
                k ? int'(bus_s.first_cycle) : int'(bus_w.first_cycle), int'(m_first));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; en = '0; up = '0; load = '0; clr = '0; lval = '0;

        // Reset for two cycles; first_cycle then high for exactly one cycle
        tick();
        tick();
        chk("rst_first_cycle", int'(bus_w.first_cycle), 1);
        chk("rst_count_w", int'(bus_w.count), 0);
        rst = 1'b0;
        tick();
        chk("first_cycle_drops", int'(bus_s.first_cycle), 0);

        // Channel 0 counts up to LIMIT, channel 1 holds
        en = 2'b01; up = 2'b11;
        repeat (10) tick();
        chk("cnt0_at_10", int'(bus_w.count[3:0]), 10);
        chk("at_limit0_set", int'(bus_w.at_limit[0]), 1);
        chk("at_limit1_clear", int'(bus_w.at_limit[1]), 0);
        chk("any_limit_set", int'(bus_s.any_limit), 1);

        // Load max then step up: wrap to 0 / stay at 15, ovf in both
        en = '0; load = 2'b01; lval = {4'd0, 4'd15};
        tick();
        load = '0; en = 2'b01; up = 2'b01;
        tick();
        chk("wrap_cnt0", int'(bus_w.count[3:0]), 0);
        chk("wrap_ovf0", int'(bus_w.ovf[0]), 1);
        chk("sat_cnt0", int'(bus_s.count[3:0]), 15);
        en = '0; clr = 2'b01;
        tick();
        clr = '0;
        chk("ovf0_cleared", int'(bus_w.ovf[0]), 0);

        // Channel 1 decrement at zero, then clear and set in the same cycle
        en = 2'b10; up = 2'b00;
        tick();
        chk("sat_cnt1_zero", int'(bus_s.count[7:4]), 0);
        chk("sat_udf1", int'(bus_s.udf[1]), 1);
        chk("wrap_cnt1_max", int'(bus_w.count[7:4]), 15);
        clr = 2'b10;
        tick();
        chk("sat_udf1_set_wins", int'(bus_s.udf[1]), 1);
        clr = '0; en = '0;

        // Load beats enable; reset mid-count
        load = 2'b01; en = 2'b01; up = 2'b01; lval = {4'd3, 4'd7};
        tick();
        chk("load_wins", int'(bus_w.count[3:0]), 7);
        lval = {4'd3, 4'd4};
        tick();
        load = '0;
        tick();
        chk("cnt0_at_5", int'(bus_s.count[3:0]), 5);
        rst = 1'b1;
        tick();
        chk("rst_mid_count", int'(bus_s.count[3:0]), 0);
        rst = 1'b0; en = '0;
        tick();

        // Random traffic on both lanes, with corner-heavy load values
        for (int n = 0; n < 400; n++) begin
            en   = CH'($urandom);
            up   = CH'($urandom);
            clr  = '0;
            load = '0;
            for (int i = 0; i < CH; i++) begin
                int sel = $urandom_range(0, 2);
                clr[i]  = ($urandom_range(0, 5) == 0);
                load[i] = ($urandom_range(0, 7) == 0);
                lval[i*W +: W] = (sel == 0) ? 4'd0 : (sel == 1) ? 4'd15 : W'($urandom);
            end
            rst = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
